alu_share_arbiter: RTL

//  Shares one combinational 32-bit logic/ALU unit (AND/OR/ADD/...) between two

---
 rtl/alu_share_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU.
// Grants one requester, drives the ALU for ALU_LAT cycles, then returns the result.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req0/op0/a0/b0      requester 0 request, opcode, operands
//   req1/op1/a1/b1      requester 1 request, opcode, operands
//   gnt0, gnt1          one-cycle pulse: operands of that requester captured
//   done0, done1        one-cycle pulse: result valid for that requester
//   result              last completed result, held until the next completion
//   busy                high while an operation is in flight
//   alu_a/alu_b/alu_op  operands and opcode presented to the shared ALU
//   alu_r               shared ALU result
module alu_share_arbiter #(
    parameter int WIDTH      = 32,
    parameter int ALU_LAT    = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [2:0]       op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [2:0]       op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_r
);

    localparam int CW = 4;
    localparam logic [CW-1:0] CNT_INIT = CW'(ALU_LAT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;

    // Arbitration: a lone request wins outright; on a tie either
    // requester 0 (fixed) or whoever was not served last (round-robin).
    logic             any_req;
    logic             win;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    always_comb begin
        any_req = req0 | req1;
        win     = 1'b0;
        unique case ({req0, req1})
            2'b11:   win = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
            2'b01:   win = 1'b1;
            default: win = 1'b0;
        endcase
        sel_op = win ? op1 : op0;
        sel_a  = win ? a1  : a0;
        sel_b  = win ? b1  : b0;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        last_d   = last_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        result_d = result_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d  = EXEC;
                    cnt_d    = CNT_INIT;
                    owner_d  = win;
                    last_d   = win;
                    gnt0_d   = ~win;
                    gnt1_d   = win;
                    alu_a_d  = sel_a;
                    alu_b_d  = sel_b;
                    alu_op_d = sel_op;
                end
            end
            EXEC: begin
                // Only the final EXEC cycle's ALU output is trusted.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d  = IDLE;
                    result_d = alu_r;
                    done0_d  = ~owner_q;
                    done1_d  = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            owner_q  <= 1'b0;
            // Requester 0 takes the first tie after reset.
            last_q   <= 1'b1;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            result_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            result_q <= result_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
        end
    end

    assign gnt0   = gnt0_q;
    assign gnt1   = gnt1_q;
    assign done0  = done0_q;
    assign done1  = done1_q;
    assign result = result_q;
    assign busy   = (state_q == EXEC);
    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_op = alu_op_q;

endmodule
